bid_result_log: RTL and testbench

// - Downstream of the bid engine. Captures one record per completed auction round:

---
 rtl/bids22_pkg.sv | 46 ++++
 rtl/bid_result_fifo.sv | 61 ++++++
 rtl/bid_result_log.sv | 145 ++++++++++++++
 tb/tb_bid_result_log.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bids22_pkg.sv
// ============================================================================
// Package : bids22_pkg
// Shared types, error codes and winner resolution for the bid result log.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bids22_pkg;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_X    = 2'b01,
        WIN_Y    = 2'b10,
        WIN_Z    = 2'b11
    } winner_e;

    localparam logic [2:0] ERR_DUP      = 3'b101;
    localparam logic [2:0] ERR_MULTIWIN = 3'b111;

    localparam int REC_RID_W = 16;
    localparam int REC_AMT_W = 32;

    // Default record layout; the FIFO stores the same field order as a flat vector.
    typedef struct packed {
        logic [REC_RID_W-1:0] rid;
        winner_e              winner;
        logic [REC_AMT_W-1:0] amt;
        logic [2:0]           err;
    } result_rec_t;

    function automatic winner_e resolve_winner(input logic x, input logic y, input logic z);
        case ({x, y, z})
            3'b100:  return WIN_X;
            3'b010:  return WIN_Y;
            3'b001:  return WIN_Z;
            default: return WIN_NONE;
        endcase
    endfunction

    function automatic logic is_multi_win(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bid_result_fifo.sv
// ============================================================================
// Module  : bid_result_fifo
// Generic synchronous FIFO of packed result records with explicit occupancy.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bid_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 53
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wr_data;
    end

    assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];
    assign o_count   = r_count;

endmodule

`default_nettype wire

// File: rtl/bid_result_log.sv
// ============================================================================
// Module  : bid_result_log
// Logs one record per auction round into a host-drained FIFO with drop tracking.
// Optional per-winner statistics enabled by macro BID_RESULT_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bid_result_log
    import bids22_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AMT_W = 32,
    parameter int RID_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   roundOver,
    input  logic                   X_win,
    input  logic                   Y_win,
    input  logic                   Z_win,
    input  logic [AMT_W-1:0]       maxBid,
    input  logic [2:0]             err,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [RID_W-1:0]       rd_rid,
    output logic [1:0]             rd_winner,
    output logic [AMT_W-1:0]       rd_amt,
    output logic [2:0]             rd_err,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   clr_ovf,
`ifdef BID_RESULT_STATS_EN
    output logic [15:0]            x_wins,
    output logic [15:0]            y_wins,
    output logic [15:0]            z_wins,
    output logic [15:0]            none_cnt,
`endif
    output logic [7:0]             drop_cnt
);

    localparam int REC_W = RID_W + 2 + AMT_W + 3;

    logic             r_ro_q;
    logic [RID_W-1:0] r_rid;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    logic             w_cap;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    winner_e          w_win;
    logic             w_multi;
    logic [AMT_W-1:0] w_amt;
    logic [2:0]       w_err;
    logic [REC_W-1:0] w_wr_rec;
    logic [REC_W-1:0] w_rd_rec;

    assign w_cap   = roundOver && !r_ro_q;
    assign w_win   = resolve_winner(X_win, Y_win, Z_win);
    assign w_multi = is_multi_win(X_win, Y_win, Z_win);
    assign w_amt   = (w_win != WIN_NONE) ? maxBid : '0;
    assign w_err   = w_multi ? ERR_MULTIWIN : err;
    assign w_wr_rec = {r_rid, w_win, w_amt, w_err};

    assign rd_valid = !w_empty;
    assign w_pop    = rd_valid && rd_ready;
    assign w_push   = w_cap && (!w_full || w_pop);
    assign w_drop   = w_cap && w_full && !w_pop;

    bid_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_push    (w_push),
        .i_wr_data (w_wr_rec),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_rec),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (count)
    );

    assign {rd_rid, rd_winner, rd_amt, rd_err} = w_rd_rec;

    // Round counter advances on every capture, dropped or not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ro_q     <= 1'b0;
            r_rid      <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_ro_q <= roundOver;
            if (w_cap) r_rid <= r_rid + RID_W'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (clr_ovf)                 r_drop_cnt <= 8'd1;
                else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

`ifdef BID_RESULT_STATS_EN
    logic [15:0] r_x_wins;
    logic [15:0] r_y_wins;
    logic [15:0] r_z_wins;
    logic [15:0] r_none_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x_wins   <= '0;
            r_y_wins   <= '0;
            r_z_wins   <= '0;
            r_none_cnt <= '0;
        end else if (w_cap) begin
            case (w_win)
                WIN_X:   if (r_x_wins   != 16'hFFFF) r_x_wins   <= r_x_wins   + 16'd1;
                WIN_Y:   if (r_y_wins   != 16'hFFFF) r_y_wins   <= r_y_wins   + 16'd1;
                WIN_Z:   if (r_z_wins   != 16'hFFFF) r_z_wins   <= r_z_wins   + 16'd1;
                default: if (r_none_cnt != 16'hFFFF) r_none_cnt <= r_none_cnt + 16'd1;
            endcase
        end
    end

    assign x_wins   = r_x_wins;
    assign y_wins   = r_y_wins;
    assign z_wins   = r_z_wins;
    assign none_cnt = r_none_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bid_result_log.sv
// ============================================================================
// Module  : tb_bid_result_log
// Directed, table-driven bench for bid_result_log.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bid_result_log;

    localparam int DEPTH = 8;
    localparam int AMT_W = 32;
    localparam int RID_W = 16;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   roundOver;
    logic                   X_win, Y_win, Z_win;
    logic [AMT_W-1:0]       maxBid;
    logic [2:0]             err;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [RID_W-1:0]       rd_rid;
    logic [1:0]             rd_winner;
    logic [AMT_W-1:0]       rd_amt;
    logic [2:0]             rd_err;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   clr_ovf;
    logic [7:0]             drop_cnt;
`ifdef BID_RESULT_STATS_EN
    logic [15:0]            x_wins, y_wins, z_wins, none_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bid_result_log #(.DEPTH(DEPTH), .AMT_W(AMT_W), .RID_W(RID_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .roundOver (roundOver),
        .X_win     (X_win),
        .Y_win     (Y_win),
        .Z_win     (Z_win),
        .maxBid    (maxBid),
        .err       (err),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_rid    (rd_rid),
        .rd_winner (rd_winner),
        .rd_amt    (rd_amt),
        .rd_err    (rd_err),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
`ifdef BID_RESULT_STATS_EN
        .x_wins    (x_wins),
        .y_wins    (y_wins),
        .z_wins    (z_wins),
        .none_cnt  (none_cnt),
`endif
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        logic        x, y, z;
        logic [31:0] bid;
        logic [2:0]  e;
        logic [1:0]  exp_win;
        logic [31:0] exp_amt;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle strobe; the record is captured on the edge inside.
    task automatic pulse(input logic x, input logic y, input logic z,
                         input logic [31:0] bid, input logic [2:0] e);
        X_win = x; Y_win = y; Z_win = z; maxBid = bid; err = e;
        roundOver = 1'b1;
        tick();
        roundOver = 1'b0;
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h64,       3'b000, 2'b10, 32'h64,       3'b000};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h55,       3'b101, 2'b00, 32'h0,        3'b101};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h77,       3'b000, 2'b00, 32'h0,        3'b111};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 3'b010, 2'b01, 32'hDEADBEEF, 3'b010};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h1,        3'b000, 2'b11, 32'h1,        3'b000};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h99,       3'b001, 2'b00, 32'h0,        3'b111};

        reset_n = 1'b0; roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0;
        maxBid = '0; err = '0; rd_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset rd_valid", rd_valid, 0);
        chk("reset count", count, 0);
        chk("reset overflow", overflow, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        chk("reset rd_rid", rd_rid, 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            pulse(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].bid, vecs[i].e);
            chk("vec rd_valid", rd_valid, 1);
            chk("vec count", count, 1);
            chk("vec rd_rid", rd_rid, i);
            chk("vec rd_winner", rd_winner, vecs[i].exp_win);
            chk("vec rd_amt", rd_amt, vecs[i].exp_amt);
            chk("vec rd_err", rd_err, vecs[i].exp_err);
            pop_one();
            chk("vec drained count", count, 0);
        end

        // Strobe held for four cycles yields a single record.
        X_win = 1'b1; Y_win = 1'b0; Z_win = 1'b0; maxBid = 32'h5; err = 3'b000;
        roundOver = 1'b1;
        repeat (4) tick();
        roundOver = 1'b0;
        tick();
        chk("stretch count", count, 1);
        chk("stretch rd_rid", rd_rid, 6);
        chk("stretch rd_winner", rd_winner, 2'b01);
        pop_one();
        pulse(1'b1, 1'b0, 1'b0, 32'h6, 3'b000);
        chk("second pulse rd_rid", rd_rid, 7);
        pop_one();
        chk("second pulse drained", rd_valid, 0);

        // Overflow: DEPTH+2 rounds with no reads.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 32'(i), 3'b000);
            tick();
        end
        chk("ovf count", count, DEPTH);
        chk("ovf overflow", overflow, 1);
        chk("ovf drop_cnt", drop_cnt, 2);
        chk("ovf head rid", rd_rid, 0);

        // Full with pop and capture in the same cycle.
        X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b1; maxBid = 32'hAB;
        roundOver = 1'b1; rd_ready = 1'b1;
        tick();
        roundOver = 1'b0; rd_ready = 1'b0;
        chk("full+pop count", count, DEPTH);
        chk("full+pop drop_cnt", drop_cnt, 2);
        chk("full+pop head rid", rd_rid, 1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr overflow", overflow, 0);
        chk("clr drop_cnt", drop_cnt, 0);

        for (int i = 0; i < DEPTH; i++) begin
            chk("drain rd_valid", rd_valid, 1);
            chk("drain rd_rid", rd_rid, (i < DEPTH - 1) ? i + 1 : 10);
            if (i == DEPTH - 1) begin
                chk("drain last winner", rd_winner, 2'b11);
                chk("drain last amt", rd_amt, 32'hAB);
            end
            pop_one();
        end
        chk("drained rd_valid", rd_valid, 0);
        chk("drained rd_rid", rd_rid, 0);
        chk("drained count", count, 0);

        // Drop and clear in the same cycle: the drop wins.
        for (int i = 0; i < DEPTH; i++) begin
            pulse(1'b0, 1'b1, 1'b0, 32'h10, 3'b000);
            tick();
        end
        clr_ovf = 1'b1;
        pulse(1'b0, 1'b1, 1'b0, 32'h11, 3'b000);
        clr_ovf = 1'b0;
        chk("drop+clr overflow", overflow, 1);
        chk("drop+clr drop_cnt", drop_cnt, 1);
        chk("drop+clr count", count, DEPTH);

        // Reset with records queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b0, 1'b0, 32'h20, 3'b000);
            tick();
        end
        chk("pre-reset count", count, 3);
        reset_n = 1'b0;
        #1;
        chk("async reset rd_valid", rd_valid, 0);
        chk("async reset count", count, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post-reset rd_valid", rd_valid, 0);
        pulse(1'b0, 1'b1, 1'b0, 32'h30, 3'b000);
        chk("post-reset rid", rd_rid, 0);
        chk("post-reset count", count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
